sent_tx_frame_ctrl: RTL
=======================

// Module: sent_tx_frame_ctrl
// PURPOSE
// SENT (SAE J2716) transmit frame sequencer, directly upstream of the tick-rate pulse generator.
// Accepts one frame (status nibble + data nibbles) per start handshake.
// Computes the CRC-4 and drives the generator's one-hot symbol selects (sync/pulse/pause/idle)
// with the matching data_nibble, advancing one symbol per pulse_done event.
// PARAMETERS
// NUM_DATA_NIBBLES  6  data nibbles per frame, legal 1..6; always taken from the top of data_in
// PAUSE_EN          1  1: append a pause pulse after CRC; 0: frame ends after CRC nibble
// PORTS
// clk            in   1   tick clock (one SENT unit time), same clock as pulse generator
// reset          in   1   asynchronous, active-high
// start          in   1   frame request; accepted when start & ready at posedge clk
// status_nibble  in   4   status/comm nibble, latched on accept
// data_in        in   24  data nibbles, [23:20] sent first; latched on accept
// pulse_done     in   1   symbol-complete event from pulse generator
// data_nibble    out  4   nibble value for current pulse symbol
// sync           out  1   select: calibration/sync pulse
// pulse          out  1   select: nibble pulse (status, data, CRC)
// pause          out  1   select: pause pulse
// idle           out  1   select: line idle
// ready          out  1   can accept a new frame (this cycle)
// busy           out  1   frame in progress
// frame_done     out  1   1-cycle strobe after last symbol of a frame
// crc_out        out  4   CRC of the latched frame
// BEHAVIOUR
// - Reset (async): idle=1, ready=1; sync/pulse/pause/busy/frame_done=0; data_nibble=0, crc_out=0; FSM->IDLE.
//   Reset mid-frame aborts the frame; nothing is retained.
// - Selects are registered and one-hot; exactly one of sync/pulse/pause/idle is high every cycle.
// - pulse_done is edge-detected: event = 0->1 at posedge clk; a held level counts once.
//   Events in IDLE are ignored.
// - FSM: IDLE -> SYNC -> STATUS -> DATA (x NUM_DATA_NIBBLES) -> CRC -> [PAUSE if PAUSE_EN] -> IDLE/SYNC.
//   - IDLE:   idle=1, ready=1.
//   - Accept: data latched on the accept edge; next cycle sync=1, idle=0, busy=1, ready=0.
//   - SYNC/PAUSE: data_nibble=0.
//   - STATUS: pulse=1, data_nibble=status_nibble.
//   - DATA k: pulse=1, data_nibble=nibble k.
//   - CRC:    pulse=1, data_nibble=crc_out.
//   - Each pulse_done event advances one state; new selects/data_nibble appear the cycle after the event.
// - Back-to-back framing:
//   - ready also goes high during the last symbol of a frame (PAUSE, or CRC if PAUSE_EN=0).
//   - A start accepted there is held. On that symbol's pulse_done the FSM goes straight to SYNC (no idle cycle).
//   - Otherwise it returns to IDLE.
// - frame_done=1 for exactly the cycle after the final pulse_done. busy drops in that same cycle, unless a next frame was accepted.
// - CRC (J2716 recommended method, data nibbles only, status excluded):
//   - seed 4'h5; per nibble: c = T[c] ^ nibble; then one augment step: c = T[c].
//   - T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
//   - Computed from latched data; crc_out is valid the cycle after accept and held until the next accept.
// - start while not ready: ignored. data_in changes after accept: no effect on the current frame.
// TESTING
// - Reset, no start: idle=1, ready=1, busy=0, other selects 0 for 100 cycles; pulse_done pulses ignored.
// - data_in=24'h000000, status=4'h0: crc_out=4'h5.
//   Symbol order sync, status, 6 data, CRC, pause, one select per pulse_done; frame_done once; back to idle.
// - data_in=24'h123456, status=4'hA: data_nibble sequence A,1,2,3,4,5,6,2; crc_out=4'h2.
// - Second start during PAUSE of frame 1: sync asserts the cycle after pause's pulse_done, with no idle cycle between frames.
//   frame_done pulses for frame 1 at that same cycle.
// - pulse_done held high 5 cycles in STATUS: advances exactly one symbol. Reset asserted in DATA nibble 3: next cycle idle=1, ready=1.
// - PAUSE_EN=0, NUM_DATA_NIBBLES=3, data_in=24'h123xxx: 6 symbols (sync, status, 1, 2, 3, CRC), no pause.
//   CRC matches the reference model.

Source files
------------

// File: rtl/sent_tx_frame_ctrl.sv
// SENT (SAE J2716) transmit frame sequencer: latches a frame, computes its CRC-4 and steps the
// pulse generator's one-hot symbol selects one symbol per pulse_done rising edge.
module sent_tx_frame_ctrl #(
    parameter int unsigned NUM_DATA_NIBBLES = 6,
    parameter bit          PAUSE_EN         = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_status_nibble,
    input  logic [23:0] i_data_in,
    input  logic        i_pulse_done,
    output logic [3:0]  o_data_nibble,
    output logic        o_sync,
    output logic        o_pulse,
    output logic        o_pause,
    output logic        o_idle,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [3:0]  o_crc_out
);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StStatus,
        StData,
        StCrc,
        StPause
    } state_e;

    localparam logic [2:0] LastIdx = 3'(NUM_DATA_NIBBLES - 1);

    function automatic logic [3:0] crc_tab(input logic [3:0] c);
        logic [3:0] t;
        case (c)
            4'd0:    t = 4'd0;
            4'd1:    t = 4'd13;
            4'd2:    t = 4'd7;
            4'd3:    t = 4'd10;
            4'd4:    t = 4'd14;
            4'd5:    t = 4'd3;
            4'd6:    t = 4'd9;
            4'd7:    t = 4'd4;
            4'd8:    t = 4'd1;
            4'd9:    t = 4'd12;
            4'd10:   t = 4'd6;
            4'd11:   t = 4'd11;
            4'd12:   t = 4'd15;
            4'd13:   t = 4'd2;
            4'd14:   t = 4'd8;
            default: t = 4'd5;
        endcase
        return t;
    endfunction

    // Data nibbles only (status excluded), seed 5, one trailing augment step.
    function automatic logic [3:0] calc_crc(input logic [23:0] d);
        logic [3:0]  c;
        logic [23:0] sh;
        c = 4'h5;
        for (int i = 0; i < NUM_DATA_NIBBLES; i++) begin
            sh = d << (4 * i);
            c  = crc_tab(c) ^ sh[23:20];
        end
        return crc_tab(c);
    endfunction

    function automatic logic [3:0] data_nib(input logic [23:0] d, input logic [2:0] idx);
        logic [23:0] sh;
        sh = d << {idx, 2'b00};
        return sh[23:20];
    endfunction

    state_e      r_state, w_state_d;
    logic [2:0]  r_idx, w_idx_d;
    logic        r_pending, w_pending_d;
    logic        r_pd;
    logic [3:0]  r_status;
    logic [23:0] r_data;
    logic [3:0]  r_crc;
    logic        r_sync, r_pulse, r_pause, r_idle, r_busy, r_frame_done;
    logic [3:0]  r_nibble;

    logic        w_evt, w_last, w_ready, w_accept, w_done_d;
    logic        w_sync_d, w_pulse_d, w_pause_d, w_idle_d, w_busy_d;
    logic [3:0]  w_nibble_d;

    assign w_evt    = i_pulse_done & ~r_pd;
    assign w_last   = PAUSE_EN ? (r_state == StPause) : (r_state == StCrc);
    // During the last symbol only one follow-on frame can be queued.
    assign w_ready  = (r_state == StIdle) | (w_last & ~r_pending);
    assign w_accept = i_start & w_ready;

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_pending_d = r_pending;
        w_done_d    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_d = StSync;
            end
            StSync: begin
                if (w_evt) w_state_d = StStatus;
            end
            StStatus: begin
                if (w_evt) begin
                    w_state_d = StData;
                    w_idx_d   = 3'd0;
                end
            end
            StData: begin
                if (w_evt) begin
                    if (r_idx == LastIdx) w_state_d = StCrc;
                    else                  w_idx_d   = r_idx + 3'd1;
                end
            end
            StCrc: begin
                if (w_evt) begin
                    if (PAUSE_EN) begin
                        w_state_d = StPause;
                    end else begin
                        w_done_d    = 1'b1;
                        w_pending_d = 1'b0;
                        w_state_d   = (r_pending | w_accept) ? StSync : StIdle;
                    end
                end
            end
            StPause: begin
                if (w_evt) begin
                    w_done_d    = 1'b1;
                    w_pending_d = 1'b0;
                    w_state_d   = (r_pending | w_accept) ? StSync : StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_last && w_accept && !w_evt) w_pending_d = 1'b1;
    end

    // Selects and nibble are decoded from the next state so they leave the flops together.
    always_comb begin
        w_sync_d   = (w_state_d == StSync);
        w_pause_d  = (w_state_d == StPause);
        w_idle_d   = (w_state_d == StIdle);
        w_pulse_d  = (w_state_d == StStatus) | (w_state_d == StData) | (w_state_d == StCrc);
        w_busy_d   = (w_state_d != StIdle);
        w_nibble_d = 4'h0;
        case (w_state_d)
            StStatus: w_nibble_d = r_status;
            StData:   w_nibble_d = data_nib(r_data, w_idx_d);
            StCrc:    w_nibble_d = r_crc;
            default:  w_nibble_d = 4'h0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_idx        <= 3'd0;
            r_pending    <= 1'b0;
            r_pd         <= 1'b0;
            r_status     <= 4'h0;
            r_data       <= 24'h0;
            r_crc        <= 4'h0;
            r_sync       <= 1'b0;
            r_pulse      <= 1'b0;
            r_pause      <= 1'b0;
            r_idle       <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_nibble     <= 4'h0;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_pending    <= w_pending_d;
            r_pd         <= i_pulse_done;
            r_sync       <= w_sync_d;
            r_pulse      <= w_pulse_d;
            r_pause      <= w_pause_d;
            r_idle       <= w_idle_d;
            r_busy       <= w_busy_d;
            r_frame_done <= w_done_d;
            r_nibble     <= w_nibble_d;
            if (w_accept) begin
                r_status <= i_status_nibble;
                r_data   <= i_data_in;
                r_crc    <= calc_crc(i_data_in);
            end
        end
    end

    assign o_data_nibble = r_nibble;
    assign o_sync        = r_sync;
    assign o_pulse       = r_pulse;
    assign o_pause       = r_pause;
    assign o_idle        = r_idle;
    assign o_ready       = w_ready;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_crc_out     = r_crc;

endmodule
